// File: rtl/fetch_control_block.sv
// Fetch control: owns the PC / program-memory address, applies freeze and replay stalls,
// and sequences jumps with a one-cycle squash of the wrong-path fetch.
module fetch_control_block #(
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP         = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   stall_pm,
    input  logic                   jmp_en,
    input  logic [PC_WIDTH-1:0]    jmp_addr,
    input  logic [INSTR_WIDTH-1:0] pm_data,
    output logic [PC_WIDTH-1:0]    pm_addr,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    output logic                   jmp_pending,
    output logic [15:0]            stall_cycles
);

    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pend_addr;
    logic [INSTR_WIDTH-1:0] hold_reg;
    logic                   squash;

    assign pm_addr = pc;

    // A squashed slot never reaches decode, so it must never be latched as the replay copy.
    always_comb begin
        instr_out   = pm_data;
        instr_valid = 1'b1;
        if (squash) begin
            instr_out   = NOP;
            instr_valid = 1'b0;
        end else if (stall_pm) begin
            instr_out = hold_reg;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            hold_reg     <= NOP;
            squash       <= 1'b1;
            jmp_pending  <= 1'b0;
            pend_addr    <= '0;
            stall_cycles <= '0;
        end else begin
            if (!stall_pm && !squash)
                hold_reg <= instr_out;

            if (stall && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;

            if (stall) begin
                // PC and squash freeze; the latest jump seen during the stall is remembered.
                if (jmp_en) begin
                    jmp_pending <= 1'b1;
                    pend_addr   <= jmp_addr;
                end
            end else if (jmp_pending) begin
                pc          <= pend_addr;
                jmp_pending <= 1'b0;
                squash      <= 1'b1;
            end else if (jmp_en) begin
                pc     <= jmp_addr;
                squash <= 1'b1;
            end else begin
                pc     <= pc + PC_WIDTH'(1);
                squash <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_control_block.sv
// Self-checking bench for fetch_control_block: directed scenarios then random stall/jump/reset
// traffic, compared against a cycle model of the fetch rules and a synchronous memory model.
module tb_fetch_control_block;

    localparam logic [31:0] NOP_W = 32'h0;

    logic        clk = 1'b0;
    logic        reset, stall, stall_pm, jmp_en;
    logic [7:0]  jmp_addr;
    logic [31:0] pm_data;
    logic [7:0]  pm_addr;
    logic [31:0] instr_out;
    logic        instr_valid, jmp_pending;
    logic [15:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [256];
    logic [7:0]  addr_q = 8'h0;
    bit          prev_stall = 1'b0;

    // Reference model state
    bit          m_ok = 1'b0;
    int          m_pc, m_prev_pc, m_pend_addr, m_cnt;
    bit          m_squash, m_pend;
    logic [31:0] m_hold;

    always #5 clk = ~clk;

    fetch_control_block dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .stall_pm    (stall_pm),
        .jmp_en      (jmp_en),
        .jmp_addr    (jmp_addr),
        .pm_data     (pm_data),
        .pm_addr     (pm_addr),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .jmp_pending (jmp_pending),
        .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check outputs, then advance the model at posedge.
    task automatic step(input bit r, input bit s, input bit j, input logic [7:0] ja);
        logic [31:0] e_instr;
        @(negedge clk);
        reset    = r;
        stall    = s;
        jmp_en   = j;
        jmp_addr = ja;
        stall_pm = prev_stall;
        prev_stall = r ? 1'b0 : s;
        pm_data  = mem[addr_q];
        addr_q   = pm_addr;
        #1;
        e_instr = m_squash ? NOP_W : (stall_pm ? m_hold : mem[m_prev_pc]);
        if (m_ok) begin
            chk("pm_addr",      {24'h0, pm_addr},       32'(m_pc));
            chk("instr_out",    instr_out,              e_instr);
            chk("instr_valid",  {31'h0, instr_valid},   {31'h0, !m_squash});
            chk("jmp_pending",  {31'h0, jmp_pending},   {31'h0, m_pend});
            chk("stall_cycles", {16'h0, stall_cycles},  32'(m_cnt));
        end
        @(posedge clk);
        if (r) begin
            m_ok = 1'b1; m_pc = 0; m_prev_pc = 0; m_hold = NOP_W;
            m_squash = 1'b1; m_pend = 1'b0; m_pend_addr = 0; m_cnt = 0;
        end else begin
            if (!stall_pm && !m_squash) m_hold = e_instr;
            if (s) m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
            m_prev_pc = m_pc;
            if (s) begin
                if (j) begin m_pend = 1'b1; m_pend_addr = int'(ja); end
            end else if (m_pend) begin
                m_pc = m_pend_addr; m_pend = 1'b0; m_squash = 1'b1;
            end else if (j) begin
                m_pc = int'(ja); m_squash = 1'b1;
            end else begin
                m_pc = (m_pc + 1) % 256; m_squash = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; stall_pm = 1'b0; jmp_en = 1'b0;
        jmp_addr = 8'h0; pm_data = 32'h0;
        for (int a = 0; a < 256; a++) mem[a] = 32'h100 + 32'(a);

        // Reset release and free run
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        repeat (5) step(0, 0, 0, 8'h00);
        // Two-cycle stall at pm_addr 5
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        repeat (10) step(0, 0, 0, 8'h00);
        // Direct jump
        step(0, 0, 1, 8'h40);
        repeat (3) step(0, 0, 0, 8'h00);
        // Jump captured during a stall
        step(0, 1, 0, 8'h00);
        step(0, 1, 1, 8'h20);
        step(0, 1, 0, 8'h00);
        repeat (4) step(0, 0, 0, 8'h00);
        // Pending jump beats a fresh jump on the release edge
        step(0, 1, 1, 8'h30);
        step(0, 0, 1, 8'h99);
        repeat (3) step(0, 0, 0, 8'h00);
        // Later jump in the same stall overwrites the target
        step(0, 1, 1, 8'h11);
        step(0, 1, 1, 8'h22);
        repeat (3) step(0, 0, 0, 8'h00);
        // PC wrap 0xFF -> 0x00
        step(0, 0, 1, 8'hFC);
        repeat (6) step(0, 0, 0, 8'h00);
        // Reset during a stall with a pending jump
        step(0, 1, 1, 8'h55);
        step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h00);
        repeat (3) step(0, 0, 0, 8'h00);

        // Random traffic over random memory contents
        for (int a = 0; a < 256; a++) mem[a] = $urandom;
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_control_block.md
Name: fetch_control_block

Overview:
- Consumer side of the stall interface. Owns the program counter and the program-memory address.
- Applies `stall` (freeze PC) and `stall_pm` (replay held instruction) from the stall control logic.
- Sequences jumps, with a one-cycle squash of the wrong-path fetch.
- Sits between program memory (synchronous read, 1-cycle latency) and the decode stage.

Parameters:
- PC_WIDTH, 8, width of PC / program-memory address
- INSTR_WIDTH, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- NOP, 0, instruction word injected on squash/reset bubble

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  freeze PC this cycle
- stall_pm  input  1  replay held instruction this cycle (registered copy of stall, from stall control)
- jmp_en  input  1  jump request, 1-cycle pulse
- jmp_addr  input  PC_WIDTH  jump target
- pm_data  input  INSTR_WIDTH  program-memory read data for the address presented last cycle
- pm_addr  output  PC_WIDTH  program-memory address (= pc register)
- instr_out  output  INSTR_WIDTH  instruction to decode
- instr_valid  output  1  instr_out is a real, non-squashed instruction
- jmp_pending  output  1  jump captured during stall, not yet applied
- stall_cycles  output  16  saturating count of cycles with stall=1 since reset

Behaviour:
- Reset (reset=1 at edge) sets:
  - pc=RESET_PC, hold_reg=NOP, squash=1, jmp_pending=0, pend_addr=0, stall_cycles=0.
  - reset dominates all other inputs.
  - Reset mid-stall or mid-jump discards the pending jump.
- First cycle after reset: instr_out=NOP, instr_valid=0 (memory latency bubble via squash=1).
- PC update priority, evaluated each edge, highest first:
  1. reset
  2. stall=1: pc holds; if jmp_en=1, capture jmp_pending=1, pend_addr=jmp_addr (later jmp_en during the same stall overwrites pend_addr).
  3. jmp_pending=1: pc<=pend_addr, jmp_pending<=0, squash<=1.
  4. jmp_en=1: pc<=jmp_addr, squash<=1.
  5. otherwise: pc<=pc+1, wrapping modulo 2^PC_WIDTH (e.g. 0xFF -> 0x00 at PC_WIDTH=8); squash<=0.
- jmp_en arriving in the same cycle a pending jump is applied is dropped; the pending jump wins.
- Output mux (combinational), priority order:
  - squash=1: instr_out=NOP, instr_valid=0.
  - else stall_pm=1: instr_out=hold_reg, instr_valid=1.
  - else: instr_out=pm_data, instr_valid=1.
- hold_reg <= instr_out on every edge where stall_pm=0 and squash=0; otherwise hold_reg holds.
- During a stall, squash holds its value (a squash bubble is not consumed by stall cycles).
- Latency:
  - pm_addr -> instr_out is 1 cycle.
  - jump taken at edge N: the instruction at target appears at N+2; one squashed bubble at N+1.
- stall_cycles increments on each edge with stall=1 and reset=0, saturates at 0xFFFF.
- pm_addr is combinationally equal to pc; no other combinational input-to-output paths except the instr_out mux.

Test Plan:
- Reset release, memory returns pm_data=addr+0x100 -> cycle 1 instr_valid=0; then instr_out=0x100, 0x101, 0x102 on consecutive cycles; pm_addr 0,1,2,3.
- stall=1 for 2 cycles starting with pm_addr=5 (stall_pm follows 1 cycle later) -> pm_addr held at 5 for 2 cycles; instr_out repeats hold_reg during stall_pm; sequence resumes with no skipped or duplicated instruction; stall_cycles=2.
- jmp_en=1, jmp_addr=0x40 at pm_addr=0x10 -> next pm_addr=0x40; following cycle instr_valid=0, instr_out=NOP; then instr_out=0x140.
- jmp_en=1, jmp_addr=0x20 while stall=1 -> jmp_pending=1, pc held; on first stall=0 edge pm_addr=0x20, jmp_pending=0, one squashed bubble.
- PC_WIDTH=8 free-run from pm_addr=0xFE -> 0xFF, then 0x00; no stall or valid glitch.
- reset=1 asserted during stall with jmp_pending=1 -> pm_addr=RESET_PC, jmp_pending=0, stall_cycles=0, instr_valid=0 next cycle.
